prn_code_acq: RTL and testbench

Receiver-side acquisition and tracking block for the JNAV PRN chip stream. It holds a local replica of the JNAV code generator, loaded with the same 115-bit serial seed as the transmitter. It aligns the replica to an incoming chip stream by serial chip-slip search, then monitors alignment window by window and reports lock. It sits between the chip-sampling front end and the downstream despreading and navigation-data logic.

---
 rtl/prn_jnav_pkg.sv | 33 +++
 rtl/prn_replica_gen.sv | 61 ++++++
 rtl/prn_code_acq.sv | 191 +++++++++++++++++++
 tb/tb_prn_code_acq.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prn_jnav_pkg.sv
// Shared definitions for the JNAV PRN code generator and its acquisition FSM.
// Contents: register lengths, feedback/coupling tap lists, the sigma2 pair
// function and the acquisition state enum.
// The 115-bit generator state is laid out as {rf[4:0], r1[54:0], r0[54:0]}.
// The serial seed enters at bit 0 and moves towards bit 114.
package prn_jnav_pkg;

  localparam int SEED_BITS = 115;
  localparam int R0_LEN    = 55;
  localparam int R1_LEN    = 55;
  localparam int RF_LEN    = 5;

  // Tap positions inside each 55-bit register.
  localparam int R0_TAPS  [4] = '{54, 40, 23, 0};
  localparam int R1_TAPS  [4] = '{54, 47, 19, 3};
  // R1 positions that couple into the RF register.
  localparam int CPL_TAPS [3] = '{50, 31, 12};

  // Pair function: {a xor b, a and b}. The XOR of the two outputs gives a|b.
  // That is the nonlinear term that feeds the RF register.
  function automatic logic [1:0] sigma2(input logic a, input logic b);
    return {a ^ b, a & b};
  endfunction

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SEARCH = 3'd1,
    ST_SLIP   = 3'd2,
    ST_LOCKED = 3'd3,
    ST_FAIL   = 3'd4
  } acq_state_e;

endpackage

// File: rtl/prn_replica_gen.sv
// Local replica of the JNAV code generator.
// Ports:
//   clk, rst  - clock and synchronous active-high reset (clears seed and state)
//   load      - shift load_bit into the 115-bit seed chain
//   load_bit  - serial seed data
//   restart   - copy the seed chain into the running generator state
//   adv       - advance the generator by one chip
//   chip      - current replica chip, taken from the present state
module prn_replica_gen
  import prn_jnav_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic load_bit,
  input  logic restart,
  input  logic adv,
  output logic chip
);

  logic [SEED_BITS-1:0] seed_q;
  logic [SEED_BITS-1:0] st_q;
  logic [SEED_BITS-1:0] st_next;
  logic [R0_LEN-1:0]    r0;
  logic [R1_LEN-1:0]    r1;
  logic [RF_LEN-1:0]    rf;
  logic                 fb0, fb1, cpl;
  logic [1:0]           pair;

  assign r0 = st_q[R0_LEN-1:0];
  assign r1 = st_q[R0_LEN+R1_LEN-1:R0_LEN];
  assign rf = st_q[SEED_BITS-1:R0_LEN+R1_LEN];

  assign chip = r0[R0_LEN-1] ^ r1[R1_LEN-1] ^ rf[0];

  always_comb begin
    fb0 = 1'b0;
    fb1 = 1'b0;
    cpl = 1'b0;
    for (int i = 0; i < $size(R0_TAPS); i++) fb0 = fb0 ^ r0[R0_TAPS[i]];
    for (int i = 0; i < $size(R1_TAPS); i++) fb1 = fb1 ^ r1[R1_TAPS[i]];
    for (int i = 0; i < $size(CPL_TAPS); i++) cpl = cpl ^ r1[CPL_TAPS[i]];
    pair = sigma2(r0[R0_LEN-1], cpl);
    // RF feeds the two linear registers; sigma2 feeds RF back.
    st_next = {rf[RF_LEN-2:0], pair[1] ^ pair[0],
               r1[R1_LEN-2:0], fb1 ^ rf[3],
               r0[R0_LEN-2:0], fb0 ^ rf[4]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seed_q <= '0;
      st_q   <= '0;
    end else begin
      if (load) seed_q <= {seed_q[SEED_BITS-2:0], load_bit};
      if (restart) st_q <= seed_q;
      else if (adv) st_q <= st_next;
    end
  end

endmodule

// File: rtl/prn_code_acq.sv
// JNAV PRN acquisition and tracking. The block aligns a local replica to the
// received chip stream by serial chip-slip search, then tracks lock window by
// window.
// Ports:
//   clk, rst           - clock and synchronous active-high reset
//   seed_bit/valid     - serial seed load; accepted only in IDLE
//   start, abort       - begin acquisition, or return to IDLE from any state
//   chip_in/chip_valid - received chip stream
//   locked, state      - lock flag and FSM state encoding
//   slip_count         - slips in the current or last search (saturating)
//   err_count          - mismatch count of the last completed window
//   seed_ready         - 115 seed bits have been loaded since reset
// Optional feature macro PRN_ACQ_REPLICA_OUT_EN adds replica_chip and
// replica_valid. They are registered one cycle after each replica advance.
// Handshake: a chip is consumed on every rising edge where chip_valid=1.
// There is no backpressure, and cycles without chip_valid leave the search
// untouched.
module prn_code_acq
  import prn_jnav_pkg::*;
#(
  parameter int WIN_LEN  = 1023,
  parameter int MISS_MAX = 100,
  parameter int LOSS_MAX = 2,
  parameter int SLIP_MAX = 4095
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         seed_bit,
  input  logic                         seed_valid,
  input  logic                         start,
  input  logic                         abort,
  input  logic                         chip_in,
  input  logic                         chip_valid,
  output logic                         locked,
  output logic [2:0]                   state,
  output logic [15:0]                  slip_count,
  output logic [$clog2(WIN_LEN+1)-1:0] err_count,
  output logic                         seed_ready
`ifdef PRN_ACQ_REPLICA_OUT_EN
  ,
  output logic                         replica_chip,
  output logic                         replica_valid
`endif
);

  localparam int CW = $clog2(WIN_LEN + 1);
  localparam int LW = (LOSS_MAX > 1) ? $clog2(LOSS_MAX) : 1;
  localparam logic [CW-1:0] LAST_CHIP = CW'(WIN_LEN - 1);
  localparam logic [CW-1:0] MISS_LIM  = CW'(MISS_MAX);
  localparam logic [LW-1:0] LOSS_LAST = LW'(LOSS_MAX - 1);
  localparam logic [15:0]   SLIP_LIM  = 16'(SLIP_MAX);
  localparam logic [6:0]    SEED_FULL = 7'(SEED_BITS);

  acq_state_e    state_q, state_d;
  logic [6:0]    seed_cnt;
  logic [CW-1:0] chip_cnt, miss_cnt, miss_tot, err_q;
  logic [LW-1:0] loss_cnt;
  logic [15:0]   slip_q;
  logic          locked_q;
  logic          rep_chip, load, restart, adv, win_end, win_good, mism, start_ok;

  assign load       = (state_q == ST_IDLE) && seed_valid;
  assign seed_ready = (seed_cnt == SEED_FULL);
  assign start_ok   = start && !seed_valid && seed_ready;
  assign mism       = chip_in ^ rep_chip;
  // Mismatch total including the chip being sampled this cycle.
  assign miss_tot   = miss_cnt + CW'(mism);
  assign win_good   = (miss_tot <= MISS_LIM);

  assign state      = state_q;
  assign locked     = locked_q;
  assign slip_count = slip_q;
  assign err_count  = err_q;

  prn_replica_gen u_replica (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_bit (seed_bit),
    .restart  (restart),
    .adv      (adv),
    .chip     (rep_chip)
  );

  always_comb begin
    state_d = state_q;
    restart = 1'b0;
    adv     = 1'b0;
    win_end = 1'b0;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_ok) begin
            restart = 1'b1;
            state_d = ST_SEARCH;
          end
        end
        ST_SEARCH: begin
          if (chip_valid) begin
            adv = 1'b1;
            if (chip_cnt == LAST_CHIP) begin
              win_end = 1'b1;
              if (win_good)              state_d = ST_LOCKED;
              else if (slip_q == SLIP_LIM) state_d = ST_FAIL;
              else                       state_d = ST_SLIP;
            end
          end
        end
        // Swallow one chip without advancing: replica ends one chip later.
        ST_SLIP: begin
          if (chip_valid) state_d = ST_SEARCH;
        end
        ST_LOCKED: begin
          if (chip_valid) begin
            adv = 1'b1;
            if (chip_cnt == LAST_CHIP) begin
              win_end = 1'b1;
              if (!win_good && loss_cnt == LOSS_LAST) state_d = ST_SEARCH;
            end
          end
        end
        ST_FAIL: state_d = ST_FAIL;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      locked_q <= 1'b0;
      seed_cnt <= '0;
      chip_cnt <= '0;
      miss_cnt <= '0;
      err_q    <= '0;
      loss_cnt <= '0;
      slip_q   <= '0;
    end else begin
      state_q  <= state_d;
      locked_q <= (state_d == ST_LOCKED);
      if (load && seed_cnt != SEED_FULL) seed_cnt <= seed_cnt + 7'd1;
      if (restart) begin
        chip_cnt <= '0;
        miss_cnt <= '0;
        loss_cnt <= '0;
        slip_q   <= '0;
      end else if (adv) begin
        if (win_end) begin
          chip_cnt <= '0;
          miss_cnt <= '0;
          err_q    <= miss_tot;
          if (state_d == ST_SLIP && slip_q != 16'hFFFF) slip_q <= slip_q + 16'd1;
          if (state_q == ST_LOCKED) begin
            if (win_good) begin
              loss_cnt <= '0;
            end else if (state_d == ST_SEARCH) begin
              // Lock dropped: re-search from the current phase.
              loss_cnt <= '0;
              slip_q   <= '0;
            end else begin
              loss_cnt <= loss_cnt + LW'(1);
            end
          end else begin
            loss_cnt <= '0;
          end
        end else begin
          chip_cnt <= chip_cnt + CW'(1);
          miss_cnt <= miss_tot;
        end
      end else if (state_q == ST_SLIP && chip_valid) begin
        chip_cnt <= '0;
        miss_cnt <= '0;
      end
    end
  end

`ifdef PRN_ACQ_REPLICA_OUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      replica_chip  <= 1'b0;
      replica_valid <= 1'b0;
    end else begin
      replica_valid <= adv;
      if (adv) replica_chip <= rep_chip;
    end
  end
`endif

endmodule

// File: tb/tb_prn_code_acq.sv
module tb_prn_code_acq;

  localparam int WIN_LEN  = 64;
  localparam int MISS_MAX = 6;
  localparam int LOSS_MAX = 2;
  localparam int SLIP_MAX = 16;
  localparam int CW = $clog2(WIN_LEN + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SEARCH = 3'd1;
  localparam logic [2:0] S_SLIP   = 3'd2;
  localparam logic [2:0] S_LOCKED = 3'd3;
  localparam logic [2:0] S_FAIL   = 3'd4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          seed_bit = 1'b0, seed_valid = 1'b0, start = 1'b0, abort = 1'b0;
  logic          chip_in = 1'b0, chip_valid = 1'b0;
  logic          locked, seed_ready;
  logic [2:0]    state;
  logic [15:0]   slip_count;
  logic [CW-1:0] err_count;
`ifdef PRN_ACQ_REPLICA_OUT_EN
  logic          replica_chip, replica_valid;
`endif

  int checks = 0;
  int errors = 0;

  logic [114:0] mseed;
  logic         ms   [0:1023];
  logic         flip [0:1023];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  prn_code_acq #(
    .WIN_LEN(WIN_LEN), .MISS_MAX(MISS_MAX), .LOSS_MAX(LOSS_MAX), .SLIP_MAX(SLIP_MAX)
  ) dut (
    .clk(clk), .rst(rst), .seed_bit(seed_bit), .seed_valid(seed_valid),
    .start(start), .abort(abort), .chip_in(chip_in), .chip_valid(chip_valid),
    .locked(locked), .state(state), .slip_count(slip_count),
    .err_count(err_count), .seed_ready(seed_ready)
`ifdef PRN_ACQ_REPLICA_OUT_EN
    , .replica_chip(replica_chip), .replica_valid(replica_valid)
`endif
  );

  // ---------------- reference generator ----------------
  function automatic logic [114:0] m_next(input logic [114:0] s);
    logic [54:0] a, b;
    logic [4:0]  f;
    logic        fa, fb, c;
    a  = s[54:0];
    b  = s[109:55];
    f  = s[114:110];
    fa = a[54] ^ a[40] ^ a[23] ^ a[0];
    fb = b[54] ^ b[47] ^ b[19] ^ b[3];
    c  = b[50] ^ b[31] ^ b[12];
    return {f[3:0], a[54] | c, b[53:0], fb ^ f[3], a[53:0], fa ^ f[4]};
  endfunction

  task automatic build_stream();
    logic [114:0] s;
    s = mseed;
    for (int i = 0; i < 1024; i++) begin
      ms[i] = s[54] ^ s[109] ^ s[110];
      s = m_next(s);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_seed(input logic [114:0] s);
    for (int i = 114; i >= 0; i--) begin
      seed_bit = s[i];
      seed_valid = 1'b1;
      tick();
    end
    seed_valid = 1'b0;
    mseed = s;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_abort();
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  task automatic send_chip(input logic b);
    chip_in = b;
    chip_valid = 1'b1;
    tick();
    chip_valid = 1'b0;
  endtask

  task automatic clear_flip();
    for (int i = 0; i < 1024; i++) flip[i] = 1'b0;
  endtask

  // Send n model chips starting at stream index base, XORed with flip[i].
  task automatic feed(input int base, input int n);
    for (int i = 0; i < n; i++) send_chip(ms[base + i] ^ flip[i]);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    checks++; if (state !== S_IDLE) begin errors++; $display("FAIL reset_state: got %0d want %0d", state, S_IDLE); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked: got %0b want 0", locked); end
    checks++; if (slip_count !== 16'd0) begin errors++; $display("FAIL reset_slip: got %0d want 0", slip_count); end
    checks++; if (err_count !== '0) begin errors++; $display("FAIL reset_err: got %0d want 0", err_count); end
    checks++; if (seed_ready !== 1'b0) begin errors++; $display("FAIL reset_seed_ready: got %0b want 0", seed_ready); end
    do_start();
    checks++; if (state !== S_IDLE) begin errors++; $display("FAIL start_no_seed: got %0d want %0d", state, S_IDLE); end
  endtask

  task automatic test_zero_offset();
    logic [114:0] s;
    logic         b;
    s[31:0]   = $urandom();
    s[63:32]  = $urandom();
    s[95:64]  = $urandom();
    s[114:96] = 19'($urandom());
    s[0]      = 1'b1;
    load_seed(s);
    checks++; if (seed_ready !== 1'b1) begin errors++; $display("FAIL seed_ready: got %0b want 1", seed_ready); end
    // start together with seed_valid is ignored, but the bit still shifts in.
    b = 1'($urandom_range(0, 1));
    seed_bit = b;
    seed_valid = 1'b1;
    start = 1'b1;
    tick();
    seed_valid = 1'b0;
    start = 1'b0;
    mseed = {mseed[113:0], b};
    checks++; if (state !== S_IDLE) begin errors++; $display("FAIL start_with_seed: got %0d want %0d", state, S_IDLE); end
    build_stream();
    clear_flip();
    do_start();
    checks++; if (state !== S_SEARCH) begin errors++; $display("FAIL start_search: got %0d want %0d", state, S_SEARCH); end
    feed(0, 63);
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL zero_early_lock: got %0b want 0", locked); end
    feed(63, 1);
    checks++; if (state !== S_LOCKED) begin errors++; $display("FAIL zero_state: got %0d want %0d", state, S_LOCKED); end
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL zero_locked: got %0b want 1", locked); end
    checks++; if (slip_count !== 16'd0) begin errors++; $display("FAIL zero_slip: got %0d want 0", slip_count); end
    checks++; if (err_count !== 7'd0) begin errors++; $display("FAIL zero_err: got %0d want 0", err_count); end
  endtask

  task automatic test_offset_slip();
    logic [2:0] st_before;
    do_abort();
    checks++; if (state !== S_IDLE || locked !== 1'b0) begin errors++; $display("FAIL abort_locked: got state %0d locked %0b want 0/0", state, locked); end
    do_start();
    for (int i = 0; i < 3; i++) send_chip(1'($urandom_range(0, 1)));
    for (int i = 0; i < 256; i++) begin
      send_chip(ms[i]);
      if (i == 60) begin
        // Idle cycles without chip_valid must not move the FSM.
        st_before = state;
        tick();
        tick();
        checks++; if (state !== st_before) begin errors++; $display("FAIL idle_gap: got %0d want %0d", state, st_before); end
      end
      if (i == 63 - 3 + 1 - 1) begin
        checks++; if (state !== S_SLIP || slip_count !== 16'd1) begin errors++; $display("FAIL first_slip: got state %0d slip %0d want %0d/1", state, slip_count, S_SLIP); end
      end
      if (i == 254) begin
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL offset_early_lock: got %0b want 0", locked); end
      end
    end
    checks++; if (state !== S_LOCKED || locked !== 1'b1) begin errors++; $display("FAIL offset_lock: got state %0d locked %0b want %0d/1", state, locked, S_LOCKED); end
    checks++; if (slip_count !== 16'd3) begin errors++; $display("FAIL offset_slip: got %0d want 3", slip_count); end
    checks++; if (err_count !== 7'd0) begin errors++; $display("FAIL offset_err: got %0d want 0", err_count); end
  endtask

  task automatic test_miss_boundary();
    int pos [7] = '{0, 9, 17, 30, 41, 50, 63};
    do_abort();
    do_start();
    clear_flip();
    for (int i = 1; i < 7; i++) flip[pos[i]] = 1'b1;
    feed(0, 64);
    checks++; if (state !== S_LOCKED) begin errors++; $display("FAIL miss6_state: got %0d want %0d", state, S_LOCKED); end
    checks++; if (err_count !== 7'd6) begin errors++; $display("FAIL miss6_err: got %0d want 6", err_count); end
    do_abort();
    do_start();
    flip[pos[0]] = 1'b1;
    feed(0, 64);
    checks++; if (state !== S_SLIP) begin errors++; $display("FAIL miss7_state: got %0d want %0d", state, S_SLIP); end
    checks++; if (slip_count !== 16'd1) begin errors++; $display("FAIL miss7_slip: got %0d want 1", slip_count); end
    checks++; if (err_count !== 7'd7) begin errors++; $display("FAIL miss7_err: got %0d want 7", err_count); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL miss7_locked: got %0b want 0", locked); end
  endtask

  task automatic test_loss();
    do_abort();
    do_start();
    clear_flip();
    feed(0, 64);
    checks++; if (state !== S_LOCKED) begin errors++; $display("FAIL loss_lock: got %0d want %0d", state, S_LOCKED); end
    for (int i = 0; i < 10; i++) flip[i * 6] = 1'b1;
    feed(64, 64);
    checks++; if (state !== S_LOCKED || locked !== 1'b1) begin errors++; $display("FAIL loss_one_bad: got state %0d locked %0b want %0d/1", state, locked, S_LOCKED); end
    checks++; if (err_count !== 7'd10) begin errors++; $display("FAIL loss_err10: got %0d want 10", err_count); end
    clear_flip();
    feed(128, 64);
    checks++; if (state !== S_LOCKED || err_count !== 7'd0) begin errors++; $display("FAIL loss_recover: got state %0d err %0d want %0d/0", state, err_count, S_LOCKED); end
    for (int i = 0; i < 10; i++) flip[i * 6 + 1] = 1'b1;
    feed(192, 64);
    checks++; if (state !== S_LOCKED) begin errors++; $display("FAIL loss_bad_again: got %0d want %0d", state, S_LOCKED); end
    feed(256, 64);
    checks++; if (state !== S_SEARCH || locked !== 1'b0) begin errors++; $display("FAIL loss_drop: got state %0d locked %0b want %0d/0", state, locked, S_SEARCH); end
    checks++; if (slip_count !== 16'd0) begin errors++; $display("FAIL loss_slip: got %0d want 0", slip_count); end
    // The replica phase is kept, so the next clean window locks straight away.
    clear_flip();
    feed(320, 64);
    checks++; if (state !== S_LOCKED) begin errors++; $display("FAIL loss_relock: got %0d want %0d", state, S_LOCKED); end
  endtask

  task automatic test_fail_and_abort();
    do_abort();
    do_start();
    for (int i = 0; i < 1103; i++) send_chip(1'($urandom_range(0, 1)));
    checks++; if (state !== S_SEARCH) begin errors++; $display("FAIL fail_before: got %0d want %0d", state, S_SEARCH); end
    send_chip(1'($urandom_range(0, 1)));
    checks++; if (state !== S_FAIL) begin errors++; $display("FAIL fail_state: got %0d want %0d", state, S_FAIL); end
    checks++; if (slip_count !== 16'd16) begin errors++; $display("FAIL fail_slip: got %0d want 16", slip_count); end
    clear_flip();
    feed(0, 70);
    checks++; if (state !== S_FAIL || locked !== 1'b0) begin errors++; $display("FAIL fail_sticky: got state %0d locked %0b want %0d/0", state, locked, S_FAIL); end
    do_abort();
    checks++; if (state !== S_IDLE || seed_ready !== 1'b1) begin errors++; $display("FAIL fail_abort: got state %0d ready %0b want %0d/1", state, seed_ready, S_IDLE); end
    do_start();
    feed(0, 64);
    checks++; if (state !== S_LOCKED || locked !== 1'b1) begin errors++; $display("FAIL fail_relock: got state %0d locked %0b want %0d/1", state, locked, S_LOCKED); end
  endtask

  task automatic test_reset_mid_window();
    do_abort();
    do_start();
    feed(0, 30);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    checks++; if (state !== S_IDLE || seed_ready !== 1'b0) begin errors++; $display("FAIL midrst: got state %0d ready %0b want %0d/0", state, seed_ready, S_IDLE); end
    checks++; if (slip_count !== 16'd0 || err_count !== 7'd0) begin errors++; $display("FAIL midrst_counts: got slip %0d err %0d want 0/0", slip_count, err_count); end
    do_start();
    checks++; if (state !== S_IDLE) begin errors++; $display("FAIL midrst_start: got %0d want %0d", state, S_IDLE); end
  endtask

  initial begin
    test_reset();
    test_zero_offset();
    test_offset_slip();
    test_miss_boundary();
    test_loss();
    test_fail_and_abort();
    test_reset_mid_window();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
